huffman_decode: RTL and testbench

//  Downstream stage of the Huffman encoder. Consumes its serial bit stream (Bit_in qualified by Bit_valid).

---
 rtl/huffman_decode_pkg.sv | 29 ++
 rtl/huffman_decode_if.sv | 38 +++
 rtl/huffman_decode_match.sv | 27 ++
 rtl/huffman_decode.sv | 125 ++++++++++++
 tb/tb_huffman_decode.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/huffman_decode_pkg.sv
// Shared types and sizing for the Huffman encoder/decoder pair.
// The decoder tables and the encoder must agree on these constants.
package huf_pkg;

    localparam int NUM_SYM = 10;
    localparam int MAX_LEN = 5;
    localparam int SYM_W   = 4;
    localparam int LEN_W   = 3;
    localparam int BLK_LEN = 256;
    localparam int CNT_W   = 8;

    typedef logic [MAX_LEN-1:0] huf_code_t;
    typedef logic [LEN_W-1:0]   huf_len_t;
    typedef logic [SYM_W-1:0]   huf_sym_t;
    typedef logic [CNT_W-1:0]   huf_cnt_t;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } huf_state_e;

    localparam huf_len_t LEN_MAX  = huf_len_t'(MAX_LEN);
    localparam huf_len_t LEN_ONE  = huf_len_t'(1);
    localparam huf_sym_t IDX_LAST = huf_sym_t'(NUM_SYM - 1);
    localparam huf_cnt_t CNT_LAST = huf_cnt_t'(BLK_LEN - 1);

endpackage

// File: rtl/huffman_decode_if.sv
// Bit-stream input and symbol output bundle of the Huffman decoder.
// master = stream source / result consumer, slave = decoder.
interface huffman_decode_if
    import huf_pkg::*;
();

    logic     Bit_in;
    logic     Bit_valid;
    huf_sym_t Sym_out;
    logic     Sym_valid;
    logic     Table_done;
    logic     Done;
    logic     Err;
    huf_cnt_t Sym_cnt;

    modport master (
        output Bit_in,
        output Bit_valid,
        input  Sym_out,
        input  Sym_valid,
        input  Table_done,
        input  Done,
        input  Err,
        input  Sym_cnt
    );

    modport slave (
        input  Bit_in,
        input  Bit_valid,
        output Sym_out,
        output Sym_valid,
        output Table_done,
        output Done,
        output Err,
        output Sym_cnt
    );

endinterface

// File: rtl/huffman_decode_match.sv
// Parallel codeword lookup: compares {acc,len} against every table entry.
// Entries are right-aligned with zeroed upper bits, so a full-width compare is exact.
module huf_code_match
    import huf_pkg::*;
(
    input  huf_code_t                    acc_i,
    input  huf_len_t                     len_i,
    input  logic [NUM_SYM*MAX_LEN-1:0]   codes_i,
    input  logic [NUM_SYM*LEN_W-1:0]     lens_i,
    output logic                         hit_o,
    output huf_sym_t                     idx_o
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (lens_i[i*LEN_W +: LEN_W] == len_i &&
                codes_i[i*MAX_LEN +: MAX_LEN] == acc_i) begin
                hit_o = 1'b1;
                idx_o = huf_sym_t'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decode.sv
// Huffman decoder: loads a code table from the bit stream,
// then turns each following codeword into a one-cycle symbol strobe.
module huffman_decode
    import huf_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    input  logic           En,
    huffman_decode_if.slave bus
);

    huf_state_e                       state_q;
    logic [NUM_SYM-1:0][MAX_LEN-1:0]  code_q;
    logic [NUM_SYM-1:0][LEN_W-1:0]    clen_q;
    huf_code_t                        acc_q;
    huf_code_t                        acc_d;
    huf_len_t                         len_q;
    huf_len_t                         len_d;
    huf_sym_t                         idx_q;
    huf_sym_t                         sym_q;
    logic                             sym_valid_q;
    logic                             table_done_q;
    logic                             done_q;
    logic                             err_q;
    huf_cnt_t                         cnt_q;

    logic                             hit;
    huf_sym_t                         hit_idx;

    // Accumulator value including the bit on the input this cycle.
    assign acc_d = {acc_q[MAX_LEN-2:0], bus.Bit_in};
    assign len_d = len_q + LEN_ONE;

    huf_code_match u_match (
        .acc_i   (acc_d),
        .len_i   (len_d),
        .codes_i (code_q),
        .lens_i  (clen_q),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_LOAD;
            code_q       <= '0;
            clen_q       <= '0;
            acc_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sym_q        <= '0;
            sym_valid_q  <= 1'b0;
            table_done_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else if (En) begin
            sym_valid_q <= 1'b0;
            unique case (state_q)
                S_LOAD: begin
                    if (bus.Bit_valid) begin
                        if (len_q == LEN_MAX) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            acc_q <= acc_d;
                            len_q <= len_d;
                        end
                    end else if (len_q != '0) begin
                        // Run ended: len_q != 0 means the previous cycle was valid.
                        code_q[idx_q] <= acc_q;
                        clen_q[idx_q] <= len_q;
                        idx_q         <= idx_q + huf_sym_t'(1);
                        acc_q         <= '0;
                        len_q         <= '0;
                        if (idx_q == IDX_LAST) begin
                            table_done_q <= 1'b1;
                            state_q      <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (bus.Bit_valid) begin
                        if (hit) begin
                            sym_q       <= hit_idx;
                            sym_valid_q <= 1'b1;
                            acc_q       <= '0;
                            len_q       <= '0;
                            cnt_q       <= cnt_q + huf_cnt_t'(1);
                            if (cnt_q == CNT_LAST) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else if (len_d == LEN_MAX) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            acc_q <= acc_d;
                            len_q <= len_d;
                        end
                    end else if (len_q != '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end
                end
                S_DONE: begin
                end
                S_ERR: begin
                end
                default: begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Sym_out    = sym_q;
    assign bus.Sym_valid  = sym_valid_q;
    assign bus.Table_done = table_done_q;
    assign bus.Done       = done_q;
    assign bus.Err        = err_q;
    assign bus.Sym_cnt    = cnt_q;

endmodule

// File: tb/tb_huffman_decode.sv
// Directed bench for huffman_decode: table load, decode, errors,
// enable freeze, mid-run reset and a full 256-codeword block.
module tb_huffman_decode;
    import huf_pkg::*;

    logic clk;
    logic rst_n;
    logic en;
    int   checks;
    int   errors;

    huffman_decode_if bus ();

    huffman_decode dut (
        .Clk   (clk),
        .Reset (rst_n),
        .En    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] tcode [10] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100,
                               5'b00101, 5'b01100, 5'b01101, 5'b01110,
                               5'b11110, 5'b11111};
    int         tlen  [10] = '{2, 3, 3, 3, 3, 4, 4, 4, 5, 5};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are read at the same point.
    task automatic drive(input logic v, input logic b);
        bus.Bit_valid = v;
        bus.Bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [4:0] c, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, c[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Bit_valid = 1'b0;
        bus.Bit_in    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
    endtask

    task automatic load_table();
        for (int s = 0; s < 10; s++) begin
            send_code(tcode[s], tlen[s]);
            if (s == 9) check("tdone_before", 32'(bus.Table_done), 0);
            drive(1'b0, 1'b0);
        end
        check("tdone_after", 32'(bus.Table_done), 1);
        check("err_load", 32'(bus.Err), 0);
    endtask

    task automatic expect_sym(input string tag, input int s);
        check({tag, "_vld"}, 32'(bus.Sym_valid), 1);
        check({tag, "_sym"}, 32'(bus.Sym_out), 32'(s));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        en     = 1'b1;
        rst_n  = 1'b0;
        bus.Bit_valid = 1'b0;
        bus.Bit_in    = 1'b0;
        #12;
        check("rst_sym", 32'(bus.Sym_out), 0);
        check("rst_vld", 32'(bus.Sym_valid), 0);
        check("rst_tdone", 32'(bus.Table_done), 0);
        check("rst_done", 32'(bus.Done), 0);
        check("rst_err", 32'(bus.Err), 0);
        check("rst_cnt", 32'(bus.Sym_cnt), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Load, then 010 idle 011
        load_table();
        send_code(5'b00010, 3);
        expect_sym("t2a", 1);
        drive(1'b0, 1'b0);
        check("t2_strobe_len", 32'(bus.Sym_valid), 0);
        send_code(5'b00011, 3);
        expect_sym("t2b", 2);
        check("t2_cnt", 32'(bus.Sym_cnt), 2);
        drive(1'b0, 1'b0);

        // Gapless 00 11111 101 from a fresh block
        do_reset();
        load_table();
        send_code(5'b00000, 2);
        expect_sym("t3a", 0);
        send_code(5'b11111, 5);
        expect_sym("t3b", 9);
        send_code(5'b00101, 3);
        expect_sym("t3c", 4);
        check("t3_cnt", 32'(bus.Sym_cnt), 3);
        drive(1'b0, 1'b0);

        // 1110 with an En=0 idle gap in the middle
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        en = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("t5_err_frozen", 32'(bus.Err), 0);
        en = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        expect_sym("t5", 7);
        check("t5_cnt", 32'(bus.Sym_cnt), 4);

        // Reset in the middle of a codeword
        drive(1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_sym", 32'(bus.Sym_out), 0);
        check("t6_rst_tdone", 32'(bus.Table_done), 0);
        check("t6_rst_cnt", 32'(bus.Sym_cnt), 0);
        check("t6_rst_err", 32'(bus.Err), 0);
        check("t6_rst_done", 32'(bus.Done), 0);
        do_reset();
        load_table();
        for (int k = 0; k < 256; k++) begin
            send_code(tcode[k % 10], tlen[k % 10]);
            expect_sym("t6_blk", k % 10);
            check("t6_cnt", 32'(bus.Sym_cnt), 32'((k + 1) % 256));
            check("t6_done", 32'(bus.Done), (k == 255) ? 1 : 0);
        end
        send_code(5'b00000, 2);
        check("t6_post_vld", 32'(bus.Sym_valid), 0);
        check("t6_post_done", 32'(bus.Done), 1);
        check("t6_post_cnt", 32'(bus.Sym_cnt), 0);

        // Over-long table run
        do_reset();
        send_code(5'b11010, 5);
        check("t4_err5", 32'(bus.Err), 0);
        drive(1'b1, 1'b1);
        check("t4_err6", 32'(bus.Err), 1);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i[0]);
            check("t4_no_vld", 32'(bus.Sym_valid), 0);
        end
        check("t4_tdone", 32'(bus.Table_done), 0);
        check("t4_err_sticky", 32'(bus.Err), 1);

        // Codeword cut short in decode
        do_reset();
        load_table();
        drive(1'b1, 1'b1);
        check("t7_err_mid", 32'(bus.Err), 0);
        drive(1'b0, 1'b0);
        check("t7_err", 32'(bus.Err), 1);
        send_code(5'b00000, 2);
        check("t7_no_vld", 32'(bus.Sym_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
